// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB encodings (HTRANS, HSIZE, HRESP) and the SRAM slave FSM states.
// The bridge reuses the HTRANS and HSIZE encodings from this package.
package ahb_defs;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd1;
    localparam logic [2:0] HSIZE_HALF = 3'd2;
    localparam logic [2:0] HSIZE_WORD = 3'd4;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side bus bundle for the SRAM slave; the master modport is the
// bridge/decoder view, the slave modport is the SRAM view.
interface ahb_sram_slave_if;
    logic        hsel_s;
    logic [31:0] haddr_s;
    logic [1:0]  htrans_s;
    logic        hwrite_s;
    logic [2:0]  hsize_s;
    logic [31:0] hwdata_s;
    logic        hready_in;
    logic [31:0] hrdata_s;
    logic        hready_s;
    logic        hresp_s;

    modport slave (
        input  hsel_s, haddr_s, htrans_s, hwrite_s, hsize_s, hwdata_s, hready_in,
        output hrdata_s, hready_s, hresp_s
    );

    modport master (
        output hsel_s, haddr_s, htrans_s, hwrite_s, hsize_s, hwdata_s, hready_in,
        input  hrdata_s, hready_s, hresp_s
    );
endinterface

// File: rtl/ahb_lane_mask.sv
// Address-phase decode of {hsize, addr[1:0]} into a little-endian byte strobe
// plus an illegal flag for unsupported sizes or misaligned addresses.
module ahb_lane_mask
    import ahb_defs::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb,
    output logic       illegal
);

    always_comb begin
        strb    = 4'h0;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                if (addr_lo[0]) illegal = 1'b1;
                else            strb    = 4'b0011 << addr_lo;
            end
            HSIZE_WORD: begin
                if (addr_lo != 2'b00) illegal = 1'b1;
                else                  strb    = 4'hF;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with byte-lane writes, write-to-read forwarding and a
// two-cycle ERROR response. Define AHB_SLV_WAIT_EN to insert WAIT_CYC wait states.
module ahb_sram_slave
    import ahb_defs::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int WAIT_CYC  = 1
) (
    input  logic              hclk,
    input  logic              hreset_n,
    ahb_sram_slave_if.slave   bus
);

    localparam int AW = $clog2(MEM_WORDS);

    state_t          state_reg, state_next, accept_target;
    logic            ready, resp;
    logic [AW-1:0]   addr_reg;
    logic            write_reg;
    logic [3:0]      mask_reg;
    logic [31:0]     rdata_reg;

    logic [3:0]      acc_strb;
    logic            size_illegal, range_illegal, acc_illegal, accept;
    logic [AW-1:0]   acc_idx;
    logic            unused_htrans;

    logic [31:0]     mem [MEM_WORDS];
    logic [31:0]     mem_rd, fwd_word;
    logic            commit, fwd_hit;

    ahb_lane_mask u_lane_mask (
        .hsize   (bus.hsize_s),
        .addr_lo (bus.haddr_s[1:0]),
        .strb    (acc_strb),
        .illegal (size_illegal)
    );

    // Only htrans[1] distinguishes real transfers from IDLE/BUSY.
    assign unused_htrans = bus.htrans_s[0];
    assign range_illegal = {2'b00, bus.haddr_s[31:2]} >= 32'(MEM_WORDS);
    assign acc_illegal   = size_illegal | range_illegal;
    assign accept        = bus.hsel_s & bus.hready_in & bus.htrans_s[1] & ready;
    assign acc_idx       = bus.haddr_s[AW+1:2];

`ifdef AHB_SLV_WAIT_EN
    logic [3:0] wait_cnt_reg;

    always_ff @(posedge hclk) begin
        if (!hreset_n)
            wait_cnt_reg <= 4'd0;
        else if (accept && !acc_illegal)
            wait_cnt_reg <= 4'(WAIT_CYC);
        else if (state_reg == ST_WAIT)
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
    end
`endif

    always_comb begin
        accept_target = ST_DATA;
        if (acc_illegal)
            accept_target = ST_ERR1;
`ifdef AHB_SLV_WAIT_EN
        else if (WAIT_CYC != 0)
            accept_target = ST_WAIT;
`endif
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) state_reg <= ST_IDLE;
        else           state_reg <= state_next;
    end

    // Ready states (IDLE, DATA, ERR2) are the only ones that can take a new address phase.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DATA, ST_ERR2: state_next = accept ? accept_target : ST_IDLE;
`ifdef AHB_SLV_WAIT_EN
            ST_WAIT: if (wait_cnt_reg <= 4'd1) state_next = ST_DATA;
`endif
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        resp  = HRESP_OKAY;
        case (state_reg)
            ST_WAIT: ready = 1'b0;
            ST_ERR1: begin
                ready = 1'b0;
                resp  = HRESP_ERROR;
            end
            ST_ERR2: resp = HRESP_ERROR;
            default: ;
        endcase
    end

    // A write commits in its final data cycle; a read accepted in that same
    // cycle picks up the new lanes through the forwarding merge.
    assign commit  = hreset_n & (state_reg == ST_DATA) & write_reg;
    assign mem_rd  = mem[acc_idx];
    assign fwd_hit = commit & (addr_reg == acc_idx);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign fwd_word[8*gi +: 8] = (fwd_hit && mask_reg[gi]) ? bus.hwdata_s[8*gi +: 8]
                                                               : mem_rd[8*gi +: 8];
    end

    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (mask_reg[b]) mem[addr_reg][8*b +: 8] <= bus.hwdata_s[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            addr_reg  <= '0;
            write_reg <= 1'b0;
            mask_reg  <= 4'h0;
            rdata_reg <= 32'h0;
        end else if (accept) begin
            addr_reg  <= acc_idx;
            write_reg <= bus.hwrite_s & ~acc_illegal;
            mask_reg  <= acc_illegal ? 4'h0 : acc_strb;
            rdata_reg <= (!bus.hwrite_s && !acc_illegal) ? fwd_word : 32'h0;
        end
    end

    assign bus.hready_s = ready;
    assign bus.hresp_s  = resp;
    assign bus.hrdata_s = rdata_reg;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed scenarios plus random
// pipelined traffic checked against a byte-level memory model.
module tb_ahb_sram_slave;

`ifdef AHB_SLV_WAIT_EN
    localparam int WAIT_CFG = 3;
    localparam int EXP_WAIT = 3;
`else
    localparam int WAIT_CFG = 1;
    localparam int EXP_WAIT = 0;
`endif
    localparam int CYC_LIMIT = 5000;

    logic hclk = 1'b0;
    logic hreset_n = 1'b0;
    logic hin_en = 1'b1;

    ahb_sram_slave_if bus ();
    assign bus.hready_in = bus.hready_s & hin_en;

    ahb_sram_slave #(.MEM_WORDS(4096), .WAIT_CYC(WAIT_CFG)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        bit          vld;
        int          kind;      // 0 transfer, 1 IDLE, 2 BUSY
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;

    op_t         opq[$];
    logic [31:0] ref_mem [0:15];
    logic [31:0] last_rdata;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_xfer = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(logic [2:0] sz, logic [31:0] a);
        if (sz != 3'd1 && sz != 3'd2 && sz != 3'd4) return 1'b0;
        if ((a % 32'(sz)) != 0) return 1'b0;
        return (a / 4) < 4096;
    endfunction

    function automatic void model_write(logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        int idx = int'(a / 4);
        int lo  = int'(a % 4);
        for (int b = 0; b < int'(sz); b++) ref_mem[idx][8*(lo+b) +: 8] = wd[8*(lo+b) +: 8];
    endfunction

    task automatic push(input int kind, input bit wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
        op_t o;
        o.vld = 1'b1; o.kind = kind; o.wr = wr; o.addr = a; o.size = sz; o.wdata = wd;
        opq.push_back(o);
    endtask

    task automatic drive_idle();
        bus.hsel_s   = 1'b0;
        bus.htrans_s = 2'b00;
        bus.hwrite_s = 1'b0;
        bus.haddr_s  = 32'h0;
        bus.hsize_s  = 3'd4;
    endtask

    // Pipelined master: address phase of one op overlaps the data phase of the previous.
    task automatic run_queue();
        op_t ap, dp;
        int  waits, dcyc, guard;
        bit  rdy_prev, dp_legal;
        ap.vld = 1'b0; dp.vld = 1'b0;
        rdy_prev = 1'b1; waits = 0; dcyc = 0; guard = 0; dp_legal = 1'b0;
        while ((opq.size() != 0 || ap.vld || dp.vld) && guard < CYC_LIMIT) begin
            if (rdy_prev) begin
                dp = ap; dcyc = 0; waits = 0;
                dp_legal = is_legal(dp.size, dp.addr);
                if (opq.size() != 0) ap = opq.pop_front();
                else                 ap.vld = 1'b0;
            end
            bus.hsel_s   = ap.vld;
            bus.htrans_s = !ap.vld ? 2'b00 : (ap.kind == 1) ? 2'b00 : (ap.kind == 2) ? 2'b01 : 2'b10;
            bus.haddr_s  = ap.addr;
            bus.hwrite_s = ap.wr;
            bus.hsize_s  = ap.size;
            bus.hwdata_s = dp.vld ? dp.wdata : $urandom;
            if (dp.vld) begin
                if (dp.kind != 0) begin
                    check("idle_ready", 32'(bus.hready_s), 32'd1);
                    check("idle_resp", 32'(bus.hresp_s), 32'd0);
                end else if (!dp_legal) begin
                    check("err_ready", 32'(bus.hready_s), (dcyc == 0) ? 32'd0 : 32'd1);
                    check("err_resp", 32'(bus.hresp_s), 32'd1);
                    if (bus.hready_s) begin
                        check("err_rdata", bus.hrdata_s, 32'h0);
                        n_xfer++;
                        $display("xfer %0d %s a=%h sz=%0d ERROR response", n_xfer,
                                 dp.wr ? "WR" : "RD", dp.addr, dp.size);
                    end
                end else if (!bus.hready_s) begin
                    waits++;
                    check("wait_resp", 32'(bus.hresp_s), 32'd0);
                end else begin
                    check("wait_count", 32'(waits), 32'(EXP_WAIT));
                    check("okay_resp", 32'(bus.hresp_s), 32'd0);
                    if (dp.wr) begin
                        model_write(dp.addr, dp.size, dp.wdata);
                    end else begin
                        last_rdata = bus.hrdata_s;
                        check("rdata", bus.hrdata_s, ref_mem[dp.addr / 4]);
                    end
                    n_xfer++;
                    $display("xfer %0d %s a=%h sz=%0d d=%h waits=%0d", n_xfer,
                             dp.wr ? "WR" : "RD", dp.addr, dp.size,
                             dp.wr ? dp.wdata : bus.hrdata_s, waits);
                end
                dcyc++;
            end
            rdy_prev = bus.hready_s & hin_en;
            @(posedge hclk); #1;
            guard++;
        end
        if (guard >= CYC_LIMIT) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: observed %0d cycles, required fewer than %0d", guard, CYC_LIMIT);
        end
        drive_idle();
    endtask

    initial begin
        logic [2:0]  bad_sizes [0:4];
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;
        logic        exp_pre;
        bad_sizes[0] = 3'd0; bad_sizes[1] = 3'd3; bad_sizes[2] = 3'd5;
        bad_sizes[3] = 3'd6; bad_sizes[4] = 3'd7;
        last_rdata = 32'h0;
        drive_idle();
        bus.hwdata_s = 32'h0;

        repeat (3) @(posedge hclk);
        #1;
        check("rst_ready", 32'(bus.hready_s), 32'd1);
        check("rst_resp", 32'(bus.hresp_s), 32'd0);
        check("rst_rdata", bus.hrdata_s, 32'h0);
        hreset_n = 1'b1;
        @(posedge hclk); #1;

        for (int i = 0; i < 16; i++) push(0, 1'b1, 32'(i * 4), 3'd4, $urandom);
        run_queue();

        push(0, 1'b1, 32'h10, 3'd4, 32'hDEADBEEF);
        push(0, 1'b0, 32'h10, 3'd4, 32'h0);
        run_queue();
        check("word_rd", last_rdata, 32'hDEADBEEF);

        push(0, 1'b1, 32'h10, 3'd4, 32'h11223344);
        push(0, 1'b1, 32'h13, 3'd1, 32'hA5A5A5A5);
        push(1, 1'b0, 32'h10, 3'd4, 32'h0);
        push(0, 1'b0, 32'h10, 3'd4, 32'h0);
        run_queue();
        check("byte_merge", last_rdata, 32'hA5223344);

        push(0, 1'b1, 32'h20, 3'd4, 32'h12345678);
        push(0, 1'b0, 32'h20, 3'd4, 32'h0);
        run_queue();
        check("b2b_fwd", last_rdata, 32'h12345678);

        push(0, 1'b1, 32'h21, 3'd2, 32'hFFFFFFFF);
        push(0, 1'b0, 32'h4000, 3'd4, 32'h0);
        push(0, 1'b1, 32'h4000, 3'd4, 32'h0);
        push(0, 1'b0, 32'h20, 3'd4, 32'h0);
        run_queue();
        check("err_mem_kept", last_rdata, 32'h12345678);

        // Address phase blocked by hready_in=0 must not be taken.
        hin_en = 1'b0;
        bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b1;
        bus.haddr_s = 32'h34; bus.hsize_s = 3'd4; bus.hwdata_s = ~ref_mem[13];
        for (int i = 0; i < 3; i++) begin
            @(posedge hclk); #1;
            check("blk_ready", 32'(bus.hready_s), 32'd1);
            check("blk_resp", 32'(bus.hresp_s), 32'd0);
        end
        drive_idle();
        hin_en = 1'b1;
        @(posedge hclk); #1;
        push(0, 1'b0, 32'h34, 3'd4, 32'h0);
        run_queue();

        // Reset lands while an overwrite of 0x30 is still in its data phase.
        push(0, 1'b1, 32'h30, 3'd4, 32'h0BADF00D);
        run_queue();
        bus.hsel_s = 1'b1; bus.htrans_s = 2'b10; bus.hwrite_s = 1'b1;
        bus.haddr_s = 32'h30; bus.hsize_s = 3'd4;
        @(posedge hclk); #1;
        drive_idle();
        bus.hwdata_s = 32'hFFFF0000;
        exp_pre = (EXP_WAIT != 0) ? 1'b0 : 1'b1;
        check("rst_pre_ready", 32'(bus.hready_s), 32'(exp_pre));
        hreset_n = 1'b0;
        @(posedge hclk); #1;
        check("rst_mid_ready", 32'(bus.hready_s), 32'd1);
        check("rst_mid_resp", 32'(bus.hresp_s), 32'd0);
        check("rst_mid_rdata", bus.hrdata_s, 32'h0);
        hreset_n = 1'b1;
        @(posedge hclk); #1;
        push(0, 1'b0, 32'h30, 3'd4, 32'h0);
        run_queue();
        check("rst_no_commit", last_rdata, 32'h0BADF00D);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                push((r < 4) ? 1 : 2, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4),
                     3'd4, $urandom);
            end else if (r < 18) begin
                case ($urandom_range(0, 2))
                    0: begin
                        sz = bad_sizes[$urandom_range(0, 4)];
                        a  = 32'($urandom_range(0, 15) * 4);
                    end
                    1: begin
                        if ($urandom_range(0, 1) == 1) begin
                            sz = 3'd2; a = 32'($urandom_range(0, 15) * 4 + 2 * $urandom_range(0, 1) + 1);
                        end else begin
                            sz = 3'd4; a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                        end
                    end
                    default: begin
                        sz = 3'd4; a = 32'h4000 + 32'($urandom_range(0, 1000) * 4);
                    end
                endcase
                push(0, 1'($urandom_range(0, 1)), a, sz, $urandom);
            end else begin
                r  = $urandom_range(0, 2);
                sz = (r == 0) ? 3'd1 : (r == 1) ? 3'd2 : 3'd4;
                a  = 32'($urandom_range(0, 15) * 4);
                if (sz == 3'd1) a = a + 32'($urandom_range(0, 3));
                if (sz == 3'd2) a = a + 32'(2 * $urandom_range(0, 1));
                push(0, 1'($urandom_range(0, 1)), a, sz, $urandom);
            end
        end
        run_queue();

        for (int i = 0; i < 16; i++) push(0, 1'b0, 32'(i * 4), 3'd4, 32'h0);
        run_queue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter MEM_WORDS, default 4096, memory depth in 32-bit words, a power of two.
REQ-002 Parameter WAIT_CYC, default 1, wait states inserted per transfer when AHB_SLV_WAIT_EN is defined; legal range 0..15.
REQ-003 hclk  input  1  single clock; all logic is on its rising edge.
REQ-004 hreset_n  input  1  reset; synchronous, active-low.
REQ-005 hsel_s  input  1  slave select from the bridge decoder.
REQ-006 haddr_s  input  32  byte address of the address phase.
REQ-007 htrans_s  input  2  transfer type: 2'b00 IDLE, 2'b01 BUSY, 2'b10 NONSEQ, 2'b11 SEQ.
REQ-008 hwrite_s  input  1  1 means write.
REQ-009 hsize_s  input  3  transfer size: 3'd1 byte, 3'd2 halfword, 3'd4 word.
REQ-010 hwdata_s  input  32  write data, valid in the data phase.
REQ-011 hready_in  input  1  bus-wide ready; an address phase is accepted only when it is 1.
REQ-012 hrdata_s  output  32  read data, valid when hready_s is 1 in a read data phase.
REQ-013 hready_s  output  1  slave ready; 0 extends the current data phase.
REQ-014 hresp_s  output  1  0 OKAY, 1 ERROR.

Function
REQ-015 Accept condition: hsel_s & hready_in & htrans_s[1] in the address phase. On accept, register addr, size, write and lane mask.
REQ-016 FSM states are IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-017 IDLE -> WAIT on accept when the wait count is nonzero; IDLE -> DATA on accept when the wait count is 0; IDLE -> ERR1 on an illegal accept.
REQ-018 WAIT decrements the wait counter and holds hready_s=0; WAIT -> DATA when the counter reaches 0.
REQ-019 DATA drives hready_s=1 and hresp_s=0. DATA -> WAIT, DATA, ERR1 or IDLE according to any accept in the same cycle (back-to-back pipelining).
REQ-020 Illegal accept: hsize_s not in {1,2,4}, a misaligned address (halfword with addr[0]=1, word with addr[1:0]!=0), or a word index >= MEM_WORDS.
REQ-021 ERR1 drives hready_s=0 and hresp_s=1; ERR2 drives hready_s=1 and hresp_s=1 (two-cycle AHB error response). ERR2 -> IDLE, or follows REQ-019 on an accept.
REQ-022 Illegal transfers never modify memory; the read data of an illegal transfer is 32'h0.
REQ-023 Write: in the final data-phase cycle (hready_s=1), write only the byte lanes selected by size and addr[1:0]; little-endian; lanes that are not selected are unchanged.
REQ-024 Read: return the full 32-bit word at addr[..:2] in the final data-phase cycle; the master extracts the lanes.
REQ-025 Read-after-write: a read whose address phase coincides with the data phase of a write to the same word returns the merged new data (forwarding); no extra stall.
REQ-026 htrans IDLE or BUSY with hsel_s=1 gets a zero-wait OKAY and causes no memory access.
REQ-027 hready_in=0 blocks acceptance; a registered transfer is never dropped.
REQ-028 Memory is a synchronous-write register array; reads may use combinational indexing of the registered address.

Reset
REQ-029 While hreset_n=0 at a rising edge: FSM=IDLE, hready_s=1, hresp_s=0, hrdata_s=32'h0, wait counter=0, pending transfer cleared.
REQ-030 Memory contents are not reset.
REQ-031 Reset asserted mid-transfer abandons it; a pending write is not committed.

Configuration
REQ-032 Macro AHB_SLV_WAIT_EN: when defined, every accepted legal transfer gets WAIT_CYC wait cycles (hready_s=0).
REQ-033 Without AHB_SLV_WAIT_EN, the wait counter and the WAIT state are not built, and every legal transfer completes with zero wait states.
REQ-034 The error response is always two cycles, independent of AHB_SLV_WAIT_EN.

Structure
REQ-035 Shared package ahb_defs holds the HTRANS and HSIZE encodings, the HRESP values and the FSM state encodings; the bridge reuses the HTRANS and HSIZE encodings.
REQ-036 One sub-module, ahb_lane_mask: combinational {hsize, addr[1:0]} -> 4-bit byte strobe plus illegal flag, instanced once in the address phase.

Verification
REQ-037 Zero-wait build: word write 0x0000_0010 <- 0xDEADBEEF, then read 0x10 -> hrdata_s=0xDEADBEEF, hready_s=1 in each data phase, hresp_s=0.
REQ-038 Byte write 0xA5 to 0x13 over the word 0x11223344 -> a later read of 0x10 returns 0xA5223344.
REQ-039 Back-to-back write 0x20 <- 0x12345678 then read 0x20 in the next address phase -> the read returns 0x12345678 with no stall.
REQ-040 Halfword write to 0x21, or word access at 0x4000 with MEM_WORDS=4096 -> cycle 1 hready_s=0/hresp_s=1, cycle 2 hready_s=1/hresp_s=1; memory unchanged.
REQ-041 AHB_SLV_WAIT_EN with WAIT_CYC=3 -> each transfer shows exactly 3 cycles of hready_s=0 before completion; hready_in=0 during an address phase -> no accept.
REQ-042 Assert hreset_n=0 in a write WAIT cycle -> next cycle hready_s=1, hresp_s=0, FSM IDLE; a readback of the target word shows its old value.
